freq_meter_mc: RTL and testbench

Multi-channel, parametrised frequency meter. It counts rising edges on CH_NUM asynchronous inputs over a programmable gate window of gate_len clk_base cycles. At the end of each window it latches all counts at once and raises a ready/acknowledge flag for the Nios readout logic. Windows run back-to-back with no dead cycles while enable is high.

---
 rtl/freq_meter_mc.sv | 150 +++++++++++++++
 tb/tb_freq_meter_mc.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter_mc.sv
// Multi-channel frequency meter.
// Counts rising edges on CH_NUM asynchronous inputs over a gate window of
// len_r clk_base cycles. All counts are latched together at the end of each
// window, and a sticky data_ready / overrun pair signals the readout side.
// While enable stays high, windows follow each other with no dead cycles.
//
// Handshake: data_ready rises together with meas_done. The reader
// acknowledges with a single-cycle data_ack pulse, which clears data_ready
// and overrun. If a new result is latched while data_ready is still set and
// no data_ack arrives in that same cycle, overrun is set. A data_ack that
// coincides with the latch cycle keeps data_ready at 1 and clears overrun.
module freq_meter_mc #(
  parameter int CH_NUM      = 4,
  parameter int CNT_W       = 32,
  parameter int GATE_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk_base,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [GATE_W-1:0]         gate_len,
  input  logic [CH_NUM-1:0]         clk_in,
  output logic [CH_NUM*CNT_W-1:0]   freq_mem,
  output logic [CH_NUM-1:0]         ovf,
  output logic                      meas_done,
  output logic                      data_ready,
  input  logic                      data_ack,
  output logic                      overrun,
  output logic                      busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state;
  logic [CH_NUM-1:0]   sync_q [SYNC_STAGES];
  logic [CH_NUM-1:0]   prev_q;
  logic [CH_NUM-1:0]   edge_q;
  logic [CNT_W-1:0]    cnt_q [CH_NUM];
  logic [CH_NUM-1:0]   sat_q;
  logic [GATE_W-1:0]   gate_cnt;
  logic [GATE_W-1:0]   len_r;

  logic [CNT_W-1:0]    cnt_next [CH_NUM];
  logic [CH_NUM-1:0]   sat_now;
  logic                win_end;
  logic                start_ok;

  // Synchronise each input, then register a one-cycle rising-edge strobe.
  always_ff @(posedge clk_base or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      edge_q <= '0;
    end else begin
      sync_q[0] <= clk_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
      edge_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  // Saturating next-count per channel; sat_now flags an edge lost at the ceiling.
  always_comb begin
    for (int k = 0; k < CH_NUM; k++) begin
      sat_now[k]  = 1'b0;
      cnt_next[k] = cnt_q[k];
    end
    for (int k = 0; k < CH_NUM; k++) begin
      sat_now[k]  = (cnt_q[k] == CNT_MAX) && edge_q[k];
      cnt_next[k] = sat_now[k] ? CNT_MAX : (cnt_q[k] + CNT_W'(edge_q[k]));
    end
  end

  assign win_end  = (state == RUN) && (gate_cnt == (len_r - GATE_W'(1)));
  assign start_ok = enable && (gate_len != '0);
  assign busy     = (state == RUN);

  // Window FSM: counting, gate timing, end-of-window latch and restart/abort.
  always_ff @(posedge clk_base or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gate_cnt  <= '0;
      len_r     <= '0;
      sat_q     <= '0;
      freq_mem  <= '0;
      ovf       <= '0;
      meas_done <= 1'b0;
      for (int k = 0; k < CH_NUM; k++) cnt_q[k] <= '0;
    end else begin
      meas_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state    <= RUN;
            gate_cnt <= '0;
            len_r    <= gate_len;
            sat_q    <= '0;
            for (int k = 0; k < CH_NUM; k++) cnt_q[k] <= '0;
          end
        end
        RUN: begin
          if (win_end) begin
            // The edge strobed in the last cycle still belongs to this window.
            for (int k = 0; k < CH_NUM; k++) begin
              freq_mem[k*CNT_W +: CNT_W] <= cnt_next[k];
              cnt_q[k]                   <= '0;
            end
            ovf       <= sat_q | sat_now;
            meas_done <= 1'b1;
            sat_q     <= '0;
            gate_cnt  <= '0;
            if (start_ok) len_r <= gate_len;
            else          state <= IDLE;
          end else if (!enable) begin
            // Abort: drop the partial window, keep the last result.
            state    <= IDLE;
            gate_cnt <= '0;
            sat_q    <= '0;
            for (int k = 0; k < CH_NUM; k++) cnt_q[k] <= '0;
          end else begin
            for (int k = 0; k < CH_NUM; k++) cnt_q[k] <= cnt_next[k];
            sat_q    <= sat_q | sat_now;
            gate_cnt <= gate_cnt + GATE_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Readout handshake: sticky data_ready and overrun, cleared by data_ack.
  always_ff @(posedge clk_base or negedge rst_n) begin
    if (!rst_n) begin
      data_ready <= 1'b0;
      overrun    <= 1'b0;
    end else if (win_end) begin
      data_ready <= 1'b1;
      overrun    <= data_ack ? 1'b0 : (overrun | data_ready);
    end else if (data_ack && data_ready) begin
      data_ready <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_freq_meter_mc.sv
// Bench for freq_meter_mc: a 32-bit-count instance for windowing, handshake,
// abort, gate changes and reset, plus an 8-bit-count instance for saturation.
module tb_freq_meter_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (CNT_W = 32)
  logic          rst_n;
  logic          enable;
  logic [31:0]   gate_len;
  logic [3:0]    clk_in;
  logic [127:0]  freq_mem;
  logic [3:0]    ovf;
  logic          meas_done;
  logic          data_ready;
  logic          data_ack;
  logic          overrun;
  logic          busy;

  // Saturation instance (CNT_W = 8)
  logic          enable8;
  logic [31:0]   gate_len8;
  logic [3:0]    clk_in8;
  logic [31:0]   freq_mem8;
  logic [3:0]    ovf8;
  logic          meas_done8;
  logic          data_ready8;
  logic          overrun8;
  logic          busy8;
  logic          tog8;

  freq_meter_mc #(.CH_NUM(4), .CNT_W(32), .GATE_W(32), .SYNC_STAGES(2)) dut (
    .clk_base   (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .gate_len   (gate_len),
    .clk_in     (clk_in),
    .freq_mem   (freq_mem),
    .ovf        (ovf),
    .meas_done  (meas_done),
    .data_ready (data_ready),
    .data_ack   (data_ack),
    .overrun    (overrun),
    .busy       (busy)
  );

  freq_meter_mc #(.CH_NUM(4), .CNT_W(8), .GATE_W(32), .SYNC_STAGES(2)) dut8 (
    .clk_base   (clk),
    .rst_n      (rst_n),
    .enable     (enable8),
    .gate_len   (gate_len8),
    .clk_in     (clk_in8),
    .freq_mem   (freq_mem8),
    .ovf        (ovf8),
    .meas_done  (meas_done8),
    .data_ready (data_ready8),
    .data_ack   (1'b0),
    .overrun    (overrun8),
    .busy       (busy8)
  );

  // Free-running cycle index, advanced on every rising edge.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Input waveforms are functions of cyc, driven on the falling edge.
  // ch0 period 10, ch1 period 4, ch2 held low, ch3 period 1000 (rises when cyc%1000==0).
  initial begin
    clk_in  = '0;
    clk_in8 = '0;
    forever begin
      @(negedge clk);
      clk_in[0]  = ((cyc % 10)   < 5);
      clk_in[1]  = ((cyc % 4)    < 2);
      clk_in[2]  = 1'b0;
      clk_in[3]  = ((cyc % 1000) < 500);
      clk_in8[0] = tog8 ? cyc[0] : 1'b0;
      clk_in8[3:1] = 3'b000;
    end
  end

  // Scoreboard
  typedef struct {
    logic [127:0] freq;
    logic [3:0]   ovf;
    logic         dr;
    logic         ov;
    int unsigned  at;
  } exp_t;

  typedef struct {
    logic [31:0]  freq;
    logic [3:0]   ovf;
    int unsigned  at;
  } exp8_t;

  exp_t  exp_q[$];
  exp8_t exp8_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_main(input logic [31:0] c3, input logic [31:0] c2,
                           input logic [31:0] c1, input logic [31:0] c0,
                           input logic [3:0] ov_f, input logic dr, input logic ov,
                           input int unsigned at);
    exp_t e;
    e.freq = {c3, c2, c1, c0};
    e.ovf  = ov_f;
    e.dr   = dr;
    e.ov   = ov;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic push8(input logic [7:0] c0, input logic [3:0] ov_f, input int unsigned at);
    exp8_t e;
    e.freq = {24'd0, c0};
    e.ovf  = ov_f;
    e.at   = at;
    exp8_q.push_back(e);
  endtask

  // Monitor for the main instance: every meas_done pops one expectation.
  exp_t m_e;
  always @(negedge clk) begin
    if (meas_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 128'(cyc), 128'(0));
      end else begin
        m_e = exp_q.pop_front();
        check("freq_mem", freq_mem, m_e.freq);
        check("ovf", 128'(ovf), 128'(m_e.ovf));
        check("data_ready", 128'(data_ready), 128'(m_e.dr));
        check("overrun", 128'(overrun), 128'(m_e.ov));
        check("done_cycle", 128'(cyc), 128'(m_e.at));
      end
    end
  end

  // Monitor for the saturation instance.
  exp8_t m8_e;
  always @(negedge clk) begin
    if (meas_done8 === 1'b1) begin
      if (exp8_q.size() == 0) begin
        check("unexpected_done8", 128'(cyc), 128'(0));
      end else begin
        m8_e = exp8_q.pop_front();
        check("freq_mem8", 128'(freq_mem8), 128'(m8_e.freq));
        check("ovf8", 128'(ovf8), 128'(m8_e.ovf));
        check("done_cycle8", 128'(cyc), 128'(m8_e.at));
      end
    end
  end

  task automatic wait_cyc(input int unsigned target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic align_1000();
    @(negedge clk);
    while ((cyc % 1000) != 0) @(negedge clk);
  endtask

  // Watchdog: the whole run is about 13k cycles.
  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete (cyc %0d)", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  int unsigned t0;
  int unsigned t1;
  int unsigned t2;

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    gate_len  = '0;
    data_ack  = 1'b0;
    enable8   = 1'b0;
    gate_len8 = '0;
    tog8      = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_freq_mem", freq_mem, 128'd0);
    check("rst_ovf", 128'(ovf), 128'd0);
    check("rst_meas_done", 128'(meas_done), 128'd0);
    check("rst_data_ready", 128'(data_ready), 128'd0);
    check("rst_overrun", 128'(overrun), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_freq_mem8", 128'(freq_mem8), 128'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", 128'(busy), 128'd0);

    // Saturation: ch0 toggles every cycle (300 edges per 600-cycle window).
    gate_len8 = 32'd600;
    t0 = cyc;
    enable8 = 1'b1;
    push8(8'd255, 4'b0001, t0 + 601);
    push8(8'd255, 4'b0001, t0 + 1201);
    push8(8'd0,   4'b0000, t0 + 1801);
    wait_cyc(t0 + 1150);
    tog8 = 1'b0;
    wait_cyc(t0 + 1810);
    enable8 = 1'b0;
    check("sat_queue_drained", 128'(exp8_q.size()), 128'd0);

    // Back-to-back 1000-cycle windows, ack, then gate_len 1000 -> 200 -> 0.
    gate_len = 32'd1000;
    align_1000();
    t0 = cyc;
    enable = 1'b1;
    push_main(32'd1, 32'd0, 32'd250, 32'd100, 4'b0000, 1'b1, 1'b0, t0 + 1001);
    push_main(32'd1, 32'd0, 32'd250, 32'd100, 4'b0000, 1'b1, 1'b1, t0 + 2001);
    push_main(32'd1, 32'd0, 32'd250, 32'd100, 4'b0000, 1'b1, 1'b1, t0 + 3001);
    push_main(32'd1, 32'd0, 32'd250, 32'd100, 4'b0000, 1'b1, 1'b0, t0 + 4001);
    push_main(32'd1, 32'd0, 32'd50,  32'd20,  4'b0000, 1'b1, 1'b1, t0 + 4201);
    push_main(32'd0, 32'd0, 32'd50,  32'd20,  4'b0000, 1'b1, 1'b1, t0 + 4401);
    wait_cyc(t0 + 1500);
    check("busy_in_run", 128'(busy), 128'd1);
    wait_cyc(t0 + 3500);
    check("overrun_before_ack", 128'(overrun), 128'd1);
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    check("ack_data_ready", 128'(data_ready), 128'd0);
    check("ack_overrun", 128'(overrun), 128'd0);
    gate_len = 32'd200;
    wait_cyc(t0 + 4300);
    gate_len = 32'd0;
    wait_cyc(t0 + 4420);
    check("gate_queue_drained", 128'(exp_q.size()), 128'd0);
    check("gate0_busy", 128'(busy), 128'd0);
    wait_cyc(t0 + 4720);
    check("gate0_stays_idle", 128'(busy), 128'd0);

    // Abort half-way through a window, then a fresh full window.
    enable = 1'b0;
    gate_len = 32'd1000;
    align_1000();
    t1 = cyc;
    enable = 1'b1;
    wait_cyc(t1 + 500);
    enable = 1'b0;
    @(negedge clk);
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_freq_mem", freq_mem, {32'd0, 32'd0, 32'd50, 32'd20});
    check("abort_ovf", 128'(ovf), 128'd0);
    check("abort_data_ready", 128'(data_ready), 128'd1);
    wait_cyc(t1 + 1700);
    align_1000();
    t2 = cyc;
    enable = 1'b1;
    push_main(32'd1, 32'd0, 32'd250, 32'd100, 4'b0000, 1'b1, 1'b1, t2 + 1001);
    wait_cyc(t2 + 1010);
    check("reenable_queue_drained", 128'(exp_q.size()), 128'd0);

    // Asynchronous reset in the middle of a running window.
    wait_cyc(t2 + 1300);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_freq_mem", freq_mem, 128'd0);
    check("arst_ovf", 128'(ovf), 128'd0);
    check("arst_data_ready", 128'(data_ready), 128'd0);
    check("arst_overrun", 128'(overrun), 128'd0);
    check("arst_busy", 128'(busy), 128'd0);
    check("arst_meas_done", 128'(meas_done), 128'd0);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_busy", 128'(busy), 128'd0);
    check("post_rst_data_ready", 128'(data_ready), 128'd0);
    check("final_queue_empty", 128'(exp_q.size() + exp8_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
